mult_arbiter: RTL
=================

# mult_arbiter

Round-robin arbiter and sequencer that shares the single dedicated hardware multiplier between NREQ requesters (e.g. the ALU multiply path and the multiply-based operand selectors). Each requester presents two unsigned WIDTH-bit operands with a valid/ready handshake. The arbiter grants one requester at a time, drives the pipelined multiplier, and returns the 2*WIDTH-bit product with a one-cycle response strobe to the granted requester. Only one operation is in flight at a time.

## Interface
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits
- NREQ, 2, number of requesters (2..4)
- LAT, 2, multiplier pipeline depth in cycles (≥1)

- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  NREQ  request i has operands on req_a[i]/req_b[i]
- req_a  input  NREQ×WIDTH  multiplicand per requester, unsigned
- req_b  input  NREQ×WIDTH  multiplier per requester, unsigned
- req_ready  output  NREQ  one-hot grant; handshake completes on an edge where req_valid[i] && req_ready[i]
- resp_valid  output  NREQ  one-hot, one-cycle pulse to the requester whose product is on resp_result
- resp_result  output  2*WIDTH  product, held stable until the next DONE
- busy  output  1  high when not in IDLE

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: if any req_valid, grant g = first asserted index at or after rr_ptr (wrapping). req_ready[g] = 1 combinationally, all other bits 0. At the edge: capture req_a[g]/req_b[g] into operand registers, latch owner = g, rr_ptr ← (g+1) mod NREQ, cnt ← LAT-1, go to BUSY. With no req_valid: stay, req_ready = 0, rr_ptr unchanged.
- BUSY: req_ready = 0. If cnt == 0 go to DONE, else cnt ← cnt-1.
- DONE: resp_valid[owner] = 1 (registered, decoded from state), resp_result = multiplier output. Unconditionally return to IDLE. No backpressure on responses.
- Arithmetic: unsigned, full 2*WIDTH-bit product, no truncation or overflow; 0xFF×0xFF = 0xFE01 at WIDTH=8.
- A requester may drop req_valid at any time before being granted. Operands are sampled only on the grant edge.
- Simultaneous requests: strictly round-robin from rr_ptr. No requester waits more than NREQ-1 grants.
- reset (any state, including mid-operation): state ← IDLE, rr_ptr ← 0, owner ← 0, cnt ← 0, operand and pipeline registers ← 0. The in-flight result is discarded and no resp_valid is issued.

## Timing
- Reset values: req_ready = 0 (asserted only once reset is deasserted and a request is present), resp_valid = 0, resp_result = 0, busy = 0.
- Accept at edge E0. resp_valid is high in the cycle after edge E_LAT, i.e. LAT cycles after the accept edge.
- Next grant is possible in the cycle after DONE, giving one operation per LAT+2 cycles.
- req_ready depends combinationally on req_valid and state. It never depends on resp_*.
- resp_result changes only at the edge entering DONE, when the last pipeline stage loads.

## Structure
- Package mult_arb_pkg: state_t enum {IDLE, BUSY, DONE} and a function for the round-robin next-grant search.
- Sub-module mult_pipe: wraps the vendor unsigned multiplier with dedicated-multiplier hint, clocked, LAT register stages, and synchronous reset clearing all stages. Inputs come from the operand registers. The arbiter contains no arithmetic itself.

## Test plan
- Reset then idle: hold reset for 3 cycles, then no requests for 10 cycles → req_ready = 0, resp_valid = 0, resp_result = 0x0000, busy = 0 throughout.
- Single request: WIDTH=8, LAT=2, req 0 with a=0x0C, b=0x0D → req_ready[0] high in the same cycle; resp_valid = 2'b01 exactly 2 cycles after the accept edge; resp_result = 0x009C; busy high for 3 cycles.
- Max operands: a=0xFF, b=0xFF on req 1 → resp_valid = 2'b10, resp_result = 0xFE01. Then a=0, b=0xFF → 0x0000.
- Contention: both requesters held valid continuously for 4 operations → grants alternate 0,1,0,1. Each response carries the correct owner bit and product. Consecutive accept edges are 4 cycles apart (LAT+2).
- Withdrawal: req 1 asserts valid and drops it during req 0's BUSY → req 1 is never granted and no spurious resp_valid[1] occurs. rr_ptr still points to 1, so a fresh req 1 is granted ahead of a simultaneous req 0.
- Mid-operation reset: assert reset for 1 cycle while in BUSY → no resp_valid for that operation. The next request is granted from index 0 with the correct product.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared types and round-robin grant search for mult_arbiter
//
// Contents:
//   MAX_NREQ      : largest supported requester count
//   IDX_W         : width of a requester index
//   state_t       : sequencer state (IDLE, BUSY, DONE)
//   rr_next_grant : first asserted valid bit at or after ptr, wrapping at nreq

package mult_arb_pkg;

  localparam int unsigned MAX_NREQ = 4;
  localparam int unsigned IDX_W    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Scans nreq positions starting at ptr. When nothing is valid the result
  // is 0; callers qualify the grant with the valid bit itself.
  function automatic logic [IDX_W-1:0] rr_next_grant(
    input logic [MAX_NREQ-1:0] valid,
    input logic [IDX_W-1:0]    ptr,
    input int unsigned         nreq
  );
    logic [IDX_W-1:0] grant;
    logic [IDX_W-1:0] idx;
    logic             found;
    grant = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < MAX_NREQ; i++) begin
      if (i < nreq) begin
        idx = IDX_W'((32'(ptr) + i) % nreq);
        if (!found && valid[idx]) begin
          grant = idx;
          found = 1'b1;
        end
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/mult_pipe.sv
// rtl/mult_pipe.sv - unsigned multiplier with LAT register stages on the dedicated multiplier
//
// Ports:
//   clk   : clock
//   reset : synchronous active-high, clears every stage
//   a, b  : WIDTH-bit unsigned operands (held stable by the caller)
//   p     : 2*WIDTH-bit product, valid LAT edges after a/b change

module mult_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LAT   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic [2*WIDTH-1:0]   p
);

  (* use_dsp = "yes" *) logic [LAT-1:0][2*WIDTH-1:0] stage_q;
  logic [LAT-1:0][2*WIDTH-1:0] stage_d;

  // Operands are zero-extended so the full product is formed without
  // truncation; later stages only shift the product down the pipe.
  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    for (int i = 1; i < LAT; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign p = stage_q[LAT-1];

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - round-robin arbiter sequencing NREQ requesters onto one shared multiplier
//
// Ports:
//   clk         : clock, all state on rising edge
//   reset       : synchronous active-high reset
//   req_valid   : [NREQ] requester i has operands on req_a[i]/req_b[i]
//   req_a/req_b : [NREQ][WIDTH] unsigned operands per requester
//   req_ready   : [NREQ] one-hot combinational grant, only in IDLE
//   resp_valid  : [NREQ] one-hot one-cycle strobe to the owner in DONE
//   resp_result : [2*WIDTH] last product, changes on the edge entering DONE
//   busy        : high whenever the sequencer is not IDLE

module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 2,
  parameter int unsigned LAT   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREQ-1:0]             req_valid,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_a,
  input  logic [NREQ-1:0][WIDTH-1:0]  req_b,
  output logic [NREQ-1:0]             req_ready,
  output logic [NREQ-1:0]             resp_valid,
  output logic [2*WIDTH-1:0]          resp_result,
  output logic                        busy
);

  localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;

  logic [MAX_NREQ-1:0] valid_pad;
  logic [IDX_W-1:0]    grant;
  logic                any_valid;
  logic [WIDTH-1:0]    sel_a, sel_b;

  // Grant search and operand mux. Indexing is done by comparison so that
  // the IDX_W-wide grant never has to address an NREQ-wide vector directly.
  always_comb begin
    valid_pad = '0;
    for (int i = 0; i < NREQ; i++) begin
      valid_pad[i] = req_valid[i];
    end
    any_valid = |req_valid;
    grant     = rr_next_grant(valid_pad, rr_ptr_q, NREQ);
    sel_a     = '0;
    sel_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDX_W'(i)) begin
        sel_a = req_a[i];
        sel_b = req_b[i];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          owner_d  = grant;
          rr_ptr_d = (grant == IDX_W'(NREQ-1)) ? '0 : grant + 1'b1;
          cnt_d    = CNT_W'(LAT-1);
          state_d  = BUSY;
        end
      end
      BUSY: begin
        // The operand registers loaded on the grant edge; after LAT edges the
        // last pipeline stage holds the product, which is the DONE entry edge.
        if (cnt_q == '0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode. req_ready is held low while reset is asserted so no
  // handshake can appear to complete on a reset edge.
  always_comb begin
    req_ready  = '0;
    resp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i]  = (state_q == IDLE) && !reset && req_valid[i] && (grant == IDX_W'(i));
      resp_valid[i] = (state_q == DONE) && (owner_q == IDX_W'(i));
    end
    busy = (state_q != IDLE);
  end

  mult_pipe #(
    .WIDTH (WIDTH),
    .LAT   (LAT)
  ) u_mult_pipe (
    .clk   (clk),
    .reset (reset),
    .a     (op_a_q),
    .b     (op_b_q),
    .p     (resp_result)
  );

endmodule
